// File: rtl/tft_spi_sink.sv
// Display-side receiver for the write-only TFT SPI link.
// Deserialises bytes, decodes CASET/PASET/RAMWR and emits addressed RGB565 pixel strobes.
module tft_spi_sink #(
    parameter int X_W         = 9,
    parameter int Y_W         = 9,
    parameter int X_RESET_END = 239,
    parameter int Y_RESET_END = 319,
    parameter int USE_CS      = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tft_clk,
    input  logic           tft_mosi,
    input  logic           tft_dc,
    input  logic           tft_cs,
    output logic           byte_valid,
    output logic [7:0]     byte_data,
    output logic           byte_dc,
    output logic           pix_valid,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic [15:0]    pix_rgb,
    output logic           cmd_unknown
);

    typedef enum logic [3:0] {
        S_IDLE, S_CA0, S_CA1, S_CA2, S_CA3,
        S_PA0, S_PA1, S_PA2, S_PA3, S_HI, S_LO
    } state_t;

    // Two-flop synchronisers; index 1 is the clk-domain view of each pin.
    logic [1:0] sclk, smosi, sdc, scs;
    logic       clk_prev;
    logic       spi_edge;
    logic       abort;

    logic [6:0] shreg;
    logic [2:0] cnt;

    state_t st, nxt;
    logic   push_param, commit_x, commit_y, ram_start, latch_hi, pix_fire, unk;

    logic [23:0]    pbuf;
    logic [7:0]     rgb_hi;
    logic [X_W-1:0] xs, xe, x;
    logic [Y_W-1:0] ys, ye, y;

    assign spi_edge = sclk[1] & ~clk_prev;
    assign abort    = (USE_CS != 0) && scs[1];

    // Synchronise the SPI pins and keep the previous clock sample for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk     <= '0;
            smosi    <= '0;
            sdc      <= '0;
            scs      <= '0;
            clk_prev <= 1'b0;
        end else begin
            sclk     <= {sclk[0], tft_clk};
            smosi    <= {smosi[0], tft_mosi};
            sdc      <= {sdc[0], tft_dc};
            scs      <= {scs[0], tft_cs};
            clk_prev <= sclk[1];
        end
    end

    // Byte assembly: shift on each rising SPI edge, publish on the 8th.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            cnt        <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_dc    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (abort) begin
                cnt <= '0;
            end else if (spi_edge) begin
                shreg <= {shreg[5:0], smosi[1]};
                cnt   <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shreg, smosi[1]};
                    byte_dc    <= sdc[1];
                end
            end
        end
    end

    // Decoder state register.
    always_ff @(posedge clk) begin
        if (rst) st <= S_IDLE;
        else     st <= nxt;
    end

    // Decoder next state and per-byte action strobes; a command byte always restarts decoding.
    always_comb begin
        nxt        = st;
        push_param = 1'b0;
        commit_x   = 1'b0;
        commit_y   = 1'b0;
        ram_start  = 1'b0;
        latch_hi   = 1'b0;
        pix_fire   = 1'b0;
        unk        = 1'b0;
        if (abort) begin
            nxt = S_IDLE;
        end else if (byte_valid) begin
            if (!byte_dc) begin
                case (byte_data)
                    8'h2A:   nxt = S_CA0;
                    8'h2B:   nxt = S_PA0;
                    8'h2C:   begin nxt = S_HI; ram_start = 1'b1; end
                    default: begin nxt = S_IDLE; unk = 1'b1; end
                endcase
            end else begin
                case (st)
                    S_CA0:   begin nxt = S_CA1;  push_param = 1'b1; end
                    S_CA1:   begin nxt = S_CA2;  push_param = 1'b1; end
                    S_CA2:   begin nxt = S_CA3;  push_param = 1'b1; end
                    S_CA3:   begin nxt = S_IDLE; commit_x   = 1'b1; end
                    S_PA0:   begin nxt = S_PA1;  push_param = 1'b1; end
                    S_PA1:   begin nxt = S_PA2;  push_param = 1'b1; end
                    S_PA2:   begin nxt = S_PA3;  push_param = 1'b1; end
                    S_PA3:   begin nxt = S_IDLE; commit_y   = 1'b1; end
                    S_HI:    begin nxt = S_LO;   latch_hi   = 1'b1; end
                    S_LO:    begin nxt = S_HI;   pix_fire   = 1'b1; end
                    default: nxt = st;
                endcase
            end
        end
    end

    // Window registers, address counters and pixel output; windows commit only on the 4th parameter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pbuf        <= '0;
            rgb_hi      <= '0;
            xs          <= '0;
            xe          <= X_W'(X_RESET_END);
            ys          <= '0;
            ye          <= Y_W'(Y_RESET_END);
            x           <= '0;
            y           <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            cmd_unknown <= 1'b0;
        end else begin
            pix_valid   <= 1'b0;
            cmd_unknown <= unk;
            if (push_param) pbuf <= {pbuf[15:0], byte_data};
            if (commit_x) begin
                xs <= X_W'(pbuf[23:8]);
                xe <= X_W'({pbuf[7:0], byte_data});
            end
            if (commit_y) begin
                ys <= Y_W'(pbuf[23:8]);
                ye <= Y_W'({pbuf[7:0], byte_data});
            end
            if (ram_start) begin
                x <= xs;
                y <= ys;
            end
            if (latch_hi) rgb_hi <= byte_data;
            if (pix_fire) begin
                pix_valid <= 1'b1;
                pix_x     <= x;
                pix_y     <= y;
                pix_rgb   <= {rgb_hi, byte_data};
                if (x == xe) begin
                    x <= xs;
                    y <= (y == ye) ? ys : y + Y_W'(1);
                end else begin
                    x <= x + X_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tft_spi_sink.sv
// Bench for tft_spi_sink: drives SPI bytes, mirrors them into a queue-based
// model of the display protocol and compares recorded DUT events against it.
module tb_tft_spi_sink;

    localparam int XW = 9;
    localparam int YW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tft_clk = 1'b0;
    logic          tft_mosi = 1'b0;
    logic          tft_dc = 1'b0;
    logic          tft_cs = 1'b0;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_dc;
    logic          pix_valid;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [15:0]   pix_rgb;
    logic          cmd_unknown;

    tft_spi_sink #(.X_W(XW), .Y_W(YW), .X_RESET_END(239), .Y_RESET_END(319), .USE_CS(1)) dut (
        .clk(clk), .rst(rst), .tft_clk(tft_clk), .tft_mosi(tft_mosi), .tft_dc(tft_dc),
        .tft_cs(tft_cs), .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .cmd_unknown(cmd_unknown)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int rgb; int lat; } pix_t;

    // observed events
    int   dut_bytes[$];
    pix_t dut_pix[$];
    int   dut_unk;
    int   cyc;
    int   last_bv;

    // model state
    int   exp_bytes[$];
    pix_t exp_pix[$];
    int   exp_unk;
    int   m_xs, m_xe, m_ys, m_ye, m_x, m_y, m_mode, m_hi;
    bit   m_have_hi;
    int   m_par[$];

    int   passed = 0;
    int   total  = 0;

    // Record DUT events half a cycle after the edge that produced them.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (byte_valid) begin
                dut_bytes.push_back({23'd0, byte_dc, byte_data});
                last_bv = cyc;
            end
            if (pix_valid) dut_pix.push_back('{int'(pix_x), int'(pix_y), int'(pix_rgb), cyc - last_bv});
            if (cmd_unknown) dut_unk = dut_unk + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic model_reset();
        m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319;
        m_x = 0; m_y = 0; m_mode = 0; m_have_hi = 0; m_hi = 0;
        m_par.delete();
    endtask

    task automatic model_abort();
        m_mode = 0; m_have_hi = 0;
        m_par.delete();
    endtask

    // Protocol model: mode 0 idle, 1 column window, 2 page window, 3 memory write.
    task automatic model_byte(input bit dc, input int b);
        pix_t p;
        exp_bytes.push_back({dc, b[7:0]});
        if (!dc) begin
            m_par.delete();
            m_have_hi = 0;
            if (b == 'h2A) m_mode = 1;
            else if (b == 'h2B) m_mode = 2;
            else if (b == 'h2C) begin m_mode = 3; m_x = m_xs; m_y = m_ys; end
            else begin m_mode = 0; exp_unk++; end
        end else if (m_mode == 1 || m_mode == 2) begin
            m_par.push_back(b);
            if (m_par.size() == 4) begin
                if (m_mode == 1) begin
                    m_xs = (m_par[0] * 256 + m_par[1]) % (1 << XW);
                    m_xe = (m_par[2] * 256 + m_par[3]) % (1 << XW);
                end else begin
                    m_ys = (m_par[0] * 256 + m_par[1]) % (1 << YW);
                    m_ye = (m_par[2] * 256 + m_par[3]) % (1 << YW);
                end
                m_par.delete();
                m_mode = 0;
            end
        end else if (m_mode == 3) begin
            if (!m_have_hi) begin
                m_hi = b; m_have_hi = 1;
            end else begin
                p = '{m_x, m_y, m_hi * 256 + b, 1};
                exp_pix.push_back(p);
                m_have_hi = 0;
                if (m_x == m_xe) begin
                    m_x = m_xs;
                    m_y = (m_y == m_ye) ? m_ys : (m_y + 1) % (1 << YW);
                end else begin
                    m_x = (m_x + 1) % (1 << XW);
                end
            end
        end
    endtask

    task automatic send_bit(input bit dc, input bit b);
        tft_dc = dc; tft_mosi = b; tft_clk = 1'b0;
        tick(3);
        tft_clk = 1'b1;
        tick(3);
        tft_clk = 1'b0;
    endtask

    task automatic send_byte(input bit dc, input int b);
        logic [7:0] v;
        v = b[7:0];
        for (int i = 7; i >= 0; i--) send_bit(dc, v[i]);
        model_byte(dc, b);
    endtask

    task automatic send_win(input int cmd, input int s, input int e);
        send_byte(0, cmd);
        send_byte(1, (s >> 8) & 255); send_byte(1, s & 255);
        send_byte(1, (e >> 8) & 255); send_byte(1, e & 255);
    endtask

    task automatic send_pix(input int rgb);
        send_byte(1, (rgb >> 8) & 255);
        send_byte(1, rgb & 255);
    endtask

    // Compare all recorded events since the last call against the model, then clear.
    task automatic check_all(input string tag);
        tick(10);
        chk({tag, ".nbytes"}, dut_bytes.size(), exp_bytes.size());
        chk({tag, ".npix"}, dut_pix.size(), exp_pix.size());
        chk({tag, ".nunk"}, dut_unk, exp_unk);
        if (dut_bytes.size() == exp_bytes.size())
            foreach (exp_bytes[i]) chk({tag, ".byte"}, dut_bytes[i], exp_bytes[i]);
        if (dut_pix.size() == exp_pix.size())
            foreach (exp_pix[i]) begin
                chk({tag, ".x"}, dut_pix[i].x, exp_pix[i].x);
                chk({tag, ".y"}, dut_pix[i].y, exp_pix[i].y);
                chk({tag, ".rgb"}, dut_pix[i].rgb, exp_pix[i].rgb);
                chk({tag, ".lat"}, dut_pix[i].lat, exp_pix[i].lat);
            end
        dut_bytes.delete(); exp_bytes.delete();
        dut_pix.delete(); exp_pix.delete();
        dut_unk = 0; exp_unk = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".byte_valid"}, byte_valid, 0);
        chk({tag, ".byte_data"}, byte_data, 0);
        chk({tag, ".byte_dc"}, byte_dc, 0);
        chk({tag, ".pix_valid"}, pix_valid, 0);
        chk({tag, ".pix_x"}, pix_x, 0);
        chk({tag, ".pix_y"}, pix_y, 0);
        chk({tag, ".pix_rgb"}, pix_rgb, 0);
        chk({tag, ".cmd_unknown"}, cmd_unknown, 0);
    endtask

    initial begin
        int s, w, n, c;
        cyc = 0; last_bv = 0; dut_unk = 0; exp_unk = 0;
        model_reset();
        rst = 1'b1;
        tick(4);
        #1 check_reset_outputs("reset");
        @(posedge clk);
        rst = 1'b0;
        tick(4);

        // column window 10..12
        send_win('h2A, 10, 12);
        check_all("caset");

        // page window 5..6, seven red pixels wrap back to (10,5)
        send_win('h2B, 5, 6);
        send_byte(0, 'h2C);
        for (int i = 0; i < 7; i++) send_pix('hF800);
        check_all("ramwr_wrap");

        // half pixel dropped by a new RAMWR
        send_byte(0, 'h2C);
        send_byte(1, 'hAB);
        send_byte(0, 'h2C);
        send_pix('h1234);
        check_all("half_pixel");

        // truncated CASET then unknown command keeps the old window
        send_byte(0, 'h2A);
        send_byte(1, 'h00); send_byte(1, 'h01);
        send_byte(0, 'h36);
        send_byte(1, 'h55);
        send_byte(0, 'h2C);
        for (int i = 0; i < 4; i++) send_pix($urandom_range(0, 65535));
        check_all("partial_caset");

        // randomized windows, including addresses above the counter width
        for (int it = 0; it < 6; it++) begin
            s = $urandom_range(0, 700); w = $urandom_range(0, 4);
            send_win('h2A, s, s + w);
            s = $urandom_range(0, 700); w = $urandom_range(0, 3);
            send_win('h2B, s, s + w);
            if ($urandom_range(0, 1) == 1) begin
                c = $urandom_range(0, 255);
                if (c >= 'h2A && c <= 'h2C) c = 'h00;
                send_byte(0, c);
                send_byte(1, $urandom_range(0, 255));
            end
            send_byte(0, 'h2C);
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) send_pix($urandom_range(0, 65535));
            check_all("random");
        end

        // chip select aborts a partial byte
        for (int i = 0; i < 5; i++) send_bit(1, 1'b1);
        tick(3);
        tft_cs = 1'b1;
        tick(4);
        tft_cs = 1'b0;
        tick(4);
        model_abort();
        send_byte(0, 'h2C);
        send_pix('hBEEF);
        check_all("cs_abort");

        // reset in the middle of a byte
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
        tick(3);
        rst = 1'b1;
        tick(2);
        #1 check_reset_outputs("mid_rst");
        @(posedge clk);
        rst = 1'b0;
        model_reset();
        tick(4);
        check_all("mid_rst_clean");
        // default window is 240 columns: pixel 240 starts row 1
        send_byte(0, 'h2C);
        for (int i = 0; i < 241; i++) send_pix($urandom_range(0, 65535));
        check_all("default_window");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
